// File: rtl/lsu_pkg.sv
// Shared LSU types: FSM state encoding, funct3 memory-op codes and access-size decode.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_D  = 3'b011;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;
  localparam logic [2:0] MEMOP_WU = 3'b110;

  // log2 of the access size in bytes; funct3[1:0] already encodes it.
  function automatic logic [1:0] size_log2(input logic [2:0] memop);
    return memop[1:0];
  endfunction

  function automatic logic [7:0] size_mask(input logic [2:0] memop);
    case (size_log2(memop))
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response bus between the LSU memory controller and the memory slave.
interface lsu_mem_ctrl_if #(parameter int XLEN = 64);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN/8-1:0] req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store shift/strobes, load select/extend, misalignment.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]        memop,
  input  logic [2:0]        offset,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   wdata_sh,
  output logic [XLEN/8-1:0] wstrb,
  output logic [XLEN-1:0]   rdata_ext,
  output logic              misaligned
);

  localparam int STRB_W = XLEN / 8;

  logic [XLEN-1:0]   rdata_sh_s;
  logic [5:0]        bit_off_s;
  logic              sext_s;
  logic [STRB_W-1:0] mask_s;

  assign bit_off_s = {offset, 3'b000};
  assign sext_s    = ~memop[2];
  assign mask_s    = STRB_W'(size_mask(memop));

  // Lane shifting, load extension and alignment check.
  always_comb begin
    wdata_sh   = wdata << bit_off_s;
    wstrb      = mask_s << offset;
    rdata_sh_s = rdata >> bit_off_s;
    case (memop)
      MEMOP_B, MEMOP_BU: rdata_ext = {{(XLEN-8){sext_s & rdata_sh_s[7]}}, rdata_sh_s[7:0]};
      MEMOP_H, MEMOP_HU: rdata_ext = {{(XLEN-16){sext_s & rdata_sh_s[15]}}, rdata_sh_s[15:0]};
      MEMOP_W, MEMOP_WU: rdata_ext = {{(XLEN-32){sext_s & rdata_sh_s[31]}}, rdata_sh_s[31:0]};
      default:           rdata_ext = rdata_sh_s;
    endcase
    case (size_log2(memop))
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = offset[0];
      2'd2:    misaligned = |offset[1:0];
      default: misaligned = |offset;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// LSU memory controller: turns one load/store into a single aligned bus request/response
// and hands the extended result (or fault) to write-back.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            i_MemWr,
  input  logic            i_MemRd,
  input  logic [2:0]      i_MemOP,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_err,
  lsu_mem_ctrl_if.master  bus
);

  localparam int STRB_W = XLEN / 8;

  lsu_state_e        state_r, state_nxt_s;
  logic              is_mem_s, misaligned_s;
  logic [2:0]        align_op_s, align_off_s;
  logic [XLEN-1:0]   wdata_sh_s, rdata_ext_s;
  logic [STRB_W-1:0] wstrb_s;

  logic              wen_r;
  logic [XLEN-1:0]   addr_r, wdata_r, rdata_r;
  logic [STRB_W-1:0] wstrb_r;
  logic [2:0]        off_r, op_r;
  logic              err_r;

  assign is_mem_s = i_MemWr | i_MemRd;

  // Stores use the live instruction fields; loads are finished with the captured ones.
  assign align_op_s  = (state_r == ST_IDLE) ? i_MemOP     : op_r;
  assign align_off_s = (state_r == ST_IDLE) ? i_addr[2:0] : off_r;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .memop      (align_op_s),
    .offset     (align_off_s),
    .wdata      (i_wdata),
    .rdata      (bus.rsp_rdata),
    .wdata_sh   (wdata_sh_s),
    .wstrb      (wstrb_s),
    .rdata_ext  (rdata_ext_s),
    .misaligned (misaligned_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and handshake decode.
  always_comb begin
    state_nxt_s   = state_r;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_mem_s && !misaligned_s) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        bus.req_valid = 1'b1;
        if (bus.req_ready) begin
          state_nxt_s = ST_RSP;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RSP: begin
        bus.rsp_ready = 1'b1;
        if (bus.rsp_valid) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RSP;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Request capture on acceptance, result capture on the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      wstrb_r <= '0;
      off_r   <= 3'b000;
      op_r    <= 3'b000;
      rdata_r <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            wen_r   <= i_MemWr;
            addr_r  <= {i_addr[XLEN-1:3], 3'b000};
            wdata_r <= i_MemWr ? wdata_sh_s : '0;
            wstrb_r <= i_MemWr ? wstrb_s : '0;
            off_r   <= i_addr[2:0];
            op_r    <= i_MemOP;
            rdata_r <= '0;
            err_r   <= is_mem_s & misaligned_s;
          end
        end
        ST_RSP: begin
          if (bus.rsp_valid) begin
            // Write responses carry no data worth returning.
            rdata_r <= wen_r ? '0 : rdata_ext_s;
            err_r   <= bus.rsp_err;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_wen   = wen_r;
  assign bus.req_addr  = addr_r;
  assign bus.req_wdata = wdata_r;
  assign bus.req_wstrb = wstrb_r;
  assign o_rdata       = rdata_r;
  assign o_err         = err_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl: loads, stores, faults, backpressure and reset.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic            i_MemWr;
  logic            i_MemRd;
  logic [2:0]      i_MemOP;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_wdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] o_rdata;
  logic            o_err;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_ctrl_if #(.XLEN(XLEN)) bus ();

  lsu_mem_ctrl #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i_MemWr   (i_MemWr),
    .i_MemRd   (i_MemRd),
    .i_MemOP   (i_MemOP),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o_rdata   (o_rdata),
    .o_err     (o_err),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_in(input logic wr, input logic rd, input logic [2:0] op,
                          input logic [63:0] addr, input logic [63:0] wdata);
    in_valid = 1'b1;
    i_MemWr  = wr;
    i_MemRd  = rd;
    i_MemOP  = op;
    i_addr   = addr;
    i_wdata  = wdata;
  endtask

  // Finish the transaction in DONE and drop the instruction.
  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    i_MemWr   = 1'b0;
    i_MemRd   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_tests++;
    if ({in_ready, out_valid, o_err, bus.req_valid, bus.rsp_ready} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {in_ready, out_valid, o_err, bus.req_valid, bus.rsp_ready});
    end
    n_tests++;
    if (o_rdata !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h want 0", o_rdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    drive_in(1'b0, 1'b1, MEMOP_B, 64'h0000_0000_8000_0003, 64'h0);
    @(negedge clk);
    n_tests++;
    if ({bus.req_valid, bus.req_wen, bus.req_addr, bus.req_wstrb} !== {1'b1, 1'b0, 64'h0000_0000_8000_0000, 8'h00}) begin
      n_fail++;
      $display("FAIL load_req: got v=%b wen=%b addr=%h strb=%h want v=1 wen=0 addr=80000000 strb=00",
               bus.req_valid, bus.req_wen, bus.req_addr, bus.req_wstrb);
    end
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    n_tests++;
    if ({bus.rsp_ready, bus.req_valid, out_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL load_rsp_phase: got rsp_ready/req_valid/out_valid=%b want 100", {bus.rsp_ready, bus.req_valid, out_valid});
    end
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 64'h0000_0000_80FF_0000;
    bus.rsp_err   = 1'b0;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    n_tests++;
    if ({out_valid, o_err, o_rdata} !== {1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF80}) begin
      n_fail++;
      $display("FAIL load_result: got v=%b err=%b rdata=%h want v=1 err=0 rdata=ffffffffffffff80", out_valid, o_err, o_rdata);
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_tests++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL load_idle: got in_ready/out_valid=%b want 00", {in_ready, out_valid});
    end
  endtask

  task automatic test_store();
    drive_in(1'b1, 1'b0, MEMOP_H, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_1234);
    @(negedge clk);
    n_tests++;
    if ({bus.req_valid, bus.req_wen, bus.req_wstrb, bus.req_wdata, bus.req_addr} !==
        {1'b1, 1'b1, 8'hC0, 64'h1234_0000_0000_0000, 64'h0000_0000_8000_0000}) begin
      n_fail++;
      $display("FAIL store_req: got v=%b wen=%b strb=%h wdata=%h addr=%h want 1 1 c0 1234000000000000 80000000",
               bus.req_valid, bus.req_wen, bus.req_wstrb, bus.req_wdata, bus.req_addr);
    end
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    n_tests++;
    if ({out_valid, o_err, o_rdata} !== {1'b1, 1'b0, 64'h0}) begin
      n_fail++;
      $display("FAIL store_result: got v=%b err=%b rdata=%h want 1 0 0", out_valid, o_err, o_rdata);
    end
    retire();
  endtask

  task automatic test_priority_sd();
    drive_in(1'b1, 1'b1, MEMOP_D, 64'h0000_0000_8000_0008, 64'h1122_3344_5566_7788);
    @(negedge clk);
    n_tests++;
    if ({bus.req_wen, bus.req_wstrb, bus.req_wdata, bus.req_addr} !==
        {1'b1, 8'hFF, 64'h1122_3344_5566_7788, 64'h0000_0000_8000_0008}) begin
      n_fail++;
      $display("FAIL prio_sd_req: got wen=%b strb=%h wdata=%h addr=%h want 1 ff 1122334455667788 80000008",
               bus.req_wen, bus.req_wstrb, bus.req_wdata, bus.req_addr);
    end
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    retire();
  endtask

  task automatic test_misaligned();
    drive_in(1'b0, 1'b1, MEMOP_W, 64'h0000_0000_8000_0002, 64'h0);
    @(negedge clk);
    n_tests++;
    if ({bus.req_valid, out_valid, o_err, o_rdata} !== {1'b0, 1'b1, 1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL misaligned_lw: got req_v=%b out_v=%b err=%b rdata=%h want 0 1 1 0",
               bus.req_valid, out_valid, o_err, o_rdata);
    end
    retire();
    // A halfword at offset 6 is aligned, a doubleword at offset 4 is not.
    drive_in(1'b1, 1'b0, MEMOP_D, 64'h0000_0000_8000_0004, 64'h0);
    @(negedge clk);
    n_tests++;
    if ({bus.req_valid, out_valid, o_err} !== 3'b011) begin
      n_fail++;
      $display("FAIL misaligned_sd: got req_v/out_v/err=%b want 011", {bus.req_valid, out_valid, o_err});
    end
    retire();
  endtask

  task automatic test_nonmem();
    drive_in(1'b0, 1'b0, MEMOP_W, 64'h0000_0000_8000_0003, 64'h0);
    @(negedge clk);
    n_tests++;
    if ({bus.req_valid, out_valid, o_err, o_rdata} !== {1'b0, 1'b1, 1'b0, 64'h0}) begin
      n_fail++;
      $display("FAIL nonmem: got req_v=%b out_v=%b err=%b rdata=%h want 0 1 0 0",
               bus.req_valid, out_valid, o_err, o_rdata);
    end
    retire();
  endtask

  task automatic test_backpressure();
    drive_in(1'b0, 1'b1, MEMOP_HU, 64'h0000_0000_8000_0002, 64'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.req_valid, bus.req_wen, bus.req_addr, bus.req_wstrb} !== {1'b1, 1'b0, 64'h0000_0000_8000_0000, 8'h00}) begin
        n_fail++;
        $display("FAIL bp_req_hold[%0d]: got v=%b wen=%b addr=%h strb=%h want 1 0 80000000 00",
                 i, bus.req_valid, bus.req_wen, bus.req_addr, bus.req_wstrb);
      end
    end
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 64'h0000_0000_ABCD_0000;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 64'h0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({out_valid, in_ready, o_err, o_rdata} !== {1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_ABCD}) begin
        n_fail++;
        $display("FAIL bp_out_hold[%0d]: got v=%b in_ready=%b err=%b rdata=%h want 1 0 0 abcd",
                 i, out_valid, in_ready, o_err, o_rdata);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_in_ready_pulse: got %b want 1", in_ready);
    end
    @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_single_pulse: got in_ready/out_valid=%b want 00", {in_ready, out_valid});
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    i_MemRd   = 1'b0;
  endtask

  task automatic test_bus_error();
    drive_in(1'b0, 1'b1, MEMOP_D, 64'h0000_0000_8000_0010, 64'h0);
    @(negedge clk);
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1;
    bus.rsp_err   = 1'b1;
    bus.rsp_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    n_tests++;
    if ({out_valid, o_err} !== 2'b11) begin
      n_fail++;
      $display("FAIL bus_error: got out_valid/o_err=%b want 11", {out_valid, o_err});
    end
    retire();
  endtask

  task automatic test_back_to_back();
    drive_in(1'b0, 1'b0, MEMOP_B, 64'h0, 64'h0);
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({out_valid, in_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_first: got out_valid/in_ready=%b want 11", {out_valid, in_ready});
    end
    @(negedge clk);
    n_tests++;
    if ({out_valid, in_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_gap: got out_valid/in_ready=%b want 00", {out_valid, in_ready});
    end
    @(negedge clk);
    n_tests++;
    if ({out_valid, in_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_second: got out_valid/in_ready=%b want 11", {out_valid, in_ready});
    end
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_rsp();
    drive_in(1'b0, 1'b1, MEMOP_D, 64'h0000_0000_8000_0020, 64'h0);
    @(negedge clk);
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    n_tests++;
    if (bus.rsp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_rsp_pre: got rsp_ready=%b want 1", bus.rsp_ready);
    end
    out_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.rsp_ready, bus.req_valid, out_valid, in_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid_rsp_async: got rsp_ready/req_valid/out_valid/in_ready=%b want 0000",
               {bus.rsp_ready, bus.req_valid, out_valid, in_ready});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.rsp_ready, bus.req_valid, out_valid, in_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid_rsp_idle: got rsp_ready/req_valid/out_valid/in_ready=%b want 0000",
               {bus.rsp_ready, bus.req_valid, out_valid, in_ready});
    end
    drive_in(1'b0, 1'b0, MEMOP_B, 64'h0, 64'h0);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_resume: got out_valid=%b want 1", out_valid);
    end
    retire();
  endtask

  initial begin
    in_valid      = 1'b0;
    i_MemWr       = 1'b0;
    i_MemRd       = 1'b0;
    i_MemOP       = 3'b000;
    i_addr        = 64'h0;
    i_wdata       = 64'h0;
    out_ready     = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 64'h0;
    bus.rsp_err   = 1'b0;

    test_reset();
    test_load();
    test_store();
    test_priority_sd();
    test_misaligned();
    test_nonmem();
    test_backpressure();
    test_bus_error();
    test_back_to_back();
    test_reset_mid_rsp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, as the register, address and bus data width.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port in_valid, input, 1: the LSU stage holds a valid instruction.
REQ-005 SHALL have port in_ready, output, 1: the instruction is consumed and the LSU stage may advance.
REQ-006 SHALL have port i_MemWr, input, 1: store.
REQ-007 SHALL have port i_MemRd, input, 1: load.
REQ-008 SHALL have port i_MemOP, input, 3: funct3 encoding. 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-009 SHALL have port i_addr, input, XLEN: effective address.
REQ-010 SHALL have port i_wdata, input, XLEN: store data, right-aligned.
REQ-011 SHALL have port out_valid, output, 1: the result is valid toward WBU.
REQ-012 SHALL have port out_ready, input, 1: WBU accepts the result.
REQ-013 SHALL have port o_rdata, output, XLEN: extended load data; 0 for non-loads.
REQ-014 SHALL have port o_err, output, 1: access fault, qualified by out_valid.
REQ-015 SHALL have port req_valid, output, 1: bus request valid.
REQ-016 SHALL have port req_ready, input, 1: bus request accepted.
REQ-017 SHALL have port req_wen, output, 1: 1 = write, 0 = read.
REQ-018 SHALL have port req_addr, output, XLEN: address aligned to 8 bytes (bits [2:0] = 0).
REQ-019 SHALL have port req_wdata, output, XLEN: store data shifted into its byte lanes.
REQ-020 SHALL have port req_wstrb, output, XLEN/8: byte-lane write mask; 0 on reads.
REQ-021 SHALL have port rsp_valid, input, 1: bus response valid.
REQ-022 SHALL have port rsp_ready, output, 1: the controller accepts the response.
REQ-023 SHALL have port rsp_rdata, input, XLEN: full bus word.
REQ-024 SHALL have port rsp_err, input, 1: bus error, qualified by rsp_valid.

Function
REQ-025 SHALL implement the states IDLE, REQ, RSP and DONE.
REQ-026 SHALL transition from IDLE on in_valid as follows: load or store, aligned -> REQ; misaligned -> DONE with the error set; otherwise -> DONE with no error.
REQ-027 SHALL treat an access as misaligned when i_addr[2:0] is not a multiple of its size (1, 2, 4 or 8 bytes).
REQ-028 SHALL in REQ assert req_valid with req_* held stable, and SHALL move to RSP on req_ready; req_valid SHALL NOT drop before the handshake.
REQ-029 SHALL in RSP assert rsp_ready, and on rsp_valid latch the lane-selected, extended data and rsp_err, then move to DONE.
REQ-030 SHALL discard rsp_rdata for a write.
REQ-031 SHALL assert out_valid in DONE; on out_ready it SHALL assert in_ready for that cycle only and return to IDLE.
REQ-032 SHALL hold in_ready low in all other cases.
REQ-033 SHALL keep o_rdata and o_err stable while out_valid is high and out_ready is low.
REQ-034 SHALL treat i_* as stable while in_valid is high and in_ready is low; the block SHALL NOT re-latch them.
REQ-035 SHALL give i_MemWr priority when i_MemWr and i_MemRd are both set.
REQ-036 SHALL select load data as rsp_rdata >> (8*i_addr[2:0]), then sign- or zero-extend it per i_MemOP[2].
REQ-037 SHALL form req_wdata as i_wdata << (8*i_addr[2:0]) and req_wstrb as the size mask << i_addr[2:0].
REQ-038 SHALL achieve the following minimum latency from in_valid to out_valid: non-memory 1 cycle; memory 3 cycles (req_ready and rsp_valid each in their first cycle).
REQ-039 SHALL NOT issue a bus request for a misaligned or non-memory instruction.

Reset
REQ-040 SHALL on rst = 0, at once and regardless of clk, enter IDLE and drive in_ready, out_valid, o_err, req_valid and rsp_ready to 0 and o_rdata to 0.
REQ-041 SHALL abandon any outstanding bus transaction on reset mid-operation (the bus slave shares the reset) and SHALL resume sampling in IDLE on the first clk edge after rst rises.

Structure
REQ-042 SHALL place the state enum, the MemOP localparams and the size decode in the shared package lsu_pkg.
REQ-043 SHALL implement lane shifting, extension, strobes and misalignment detection in a combinational sub-module lsu_lane_align.

Verification
REQ-044 SHALL verify load: lb at 0x80000003 with rsp_rdata 0x00000000_80FF0000 -> req_addr 0x80000000, o_rdata 0xFFFFFFFF_FFFFFF80, o_err 0.
REQ-045 SHALL verify store: sh at 0x80000006 with i_wdata 0x1234 -> req_wen 1, req_wstrb 0xC0, req_wdata 0x1234_0000_0000_0000.
REQ-046 SHALL verify misaligned: lw at 0x80000002 -> no req_valid, out_valid after 1 cycle, o_err 1.
REQ-047 SHALL verify backpressure: req_ready held low 5 cycles, then out_ready held low 3 cycles -> req_* stable, o_rdata stable, a single in_ready pulse.
REQ-048 SHALL verify a bus error: a ld with rsp_err 1 -> o_err 1 with out_valid.
REQ-049 SHALL verify reset mid-RSP: rst = 0 -> rsp_ready 0 at once, IDLE, no in_ready pulse.
